// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM request arbiter.
package sdram_arb_pkg;

  localparam int unsigned OWNER_W = 1;

  typedef logic [OWNER_W-1:0] owner_t;

  localparam owner_t PORT_LCD  = 1'b0;
  localparam owner_t PORT_HOST = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Owner-tag FIFO: records which port issued each outstanding read, in issue order.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  owner_t din,
  output owner_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  owner_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the SDRAM controller; returned read beats are steered by issue order.
// Optional feature: define SDRAM_ARB_RR_EN for round-robin on contention (default: port 0 fixed priority).
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 23,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_DEPTH  = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_data,
  input  logic                  p0_we,
  input  logic                  p0_req,
  output logic                  p0_ack,
  output logic                  p0_valid,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_data,
  input  logic                  p1_we,
  input  logic                  p1_req,
  output logic                  p1_ack,
  output logic                  p1_valid,
  output logic [DATA_WIDTH-1:0] rd_q,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic [DATA_WIDTH-1:0] sdram_data,
  output logic                  sdram_we,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  input  logic                  sdram_valid,
  input  logic [DATA_WIDTH-1:0] sdram_q,
  output logic                  err_orphan
);

  arb_state_t state, state_nxt;
  owner_t     owner;
  owner_t     grant_port;
  owner_t     fifo_head;
  logic       fifo_full, fifo_empty;
  logic       fifo_push, fifo_pop;
  logic       elig0, elig1, grant_any;

  // Reads need a free tag slot; writes never return data so they are always eligible.
  assign elig0     = p0_req && (p0_we || !fifo_full);
  assign elig1     = p1_req && (p1_we || !fifo_full);
  assign grant_any = elig0 || elig1;

`ifdef SDRAM_ARB_RR_EN
  owner_t last_port;

  always_comb begin
    grant_port = elig0 ? PORT_LCD : PORT_HOST;
    if (elig0 && elig1) grant_port = (last_port == PORT_LCD) ? PORT_HOST : PORT_LCD;
  end

  // Resetting to HOST makes the first contended grant go to the LCD port.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                               last_port <= PORT_HOST;
    else if (state == IDLE && grant_any)   last_port <= grant_port;
  end
`else
  assign grant_port = elig0 ? PORT_LCD : PORT_HOST;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = BUSY;
      BUSY:    if (sdram_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sdram_addr <= '0;
      sdram_data <= '0;
      sdram_we   <= 1'b0;
      sdram_req  <= 1'b0;
      owner      <= PORT_LCD;
    end else if (state == IDLE && grant_any) begin
      sdram_addr <= (grant_port == PORT_LCD) ? p0_addr : p1_addr;
      sdram_data <= (grant_port == PORT_LCD) ? p0_data : p1_data;
      sdram_we   <= (grant_port == PORT_LCD) ? p0_we   : p1_we;
      sdram_req  <= 1'b1;
      owner      <= grant_port;
    end else if (state == BUSY && sdram_ack) begin
      sdram_req  <= 1'b0;
    end
  end

  always_comb begin
    p0_ack    = (state == BUSY) && sdram_ack && (owner == PORT_LCD);
    p1_ack    = (state == BUSY) && sdram_ack && (owner == PORT_HOST);
    fifo_push = (state == BUSY) && sdram_ack && !sdram_we;
    fifo_pop  = sdram_valid && !fifo_empty;
    p0_valid  = fifo_pop && (fifo_head == PORT_LCD);
    p1_valid  = fifo_pop && (fifo_head == PORT_HOST);
    rd_q      = sdram_q;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                             err_orphan <= 1'b0;
    else if (sdram_valid && fifo_empty)  err_orphan <= 1'b1;
  end

  sdram_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (sys_clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (owner),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: transaction-level model plus directed scenarios.
module tb_sdram_arbiter;

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;
  localparam int unsigned TD = 4;
  localparam int LIM = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_data = '0, p1_data = '0;
  logic          p0_we = 1'b0, p1_we = 1'b0;
  logic          p0_req = 1'b0, p1_req = 1'b0;
  logic          p0_ack, p1_ack, p0_valid, p1_valid;
  logic [DW-1:0] rd_q;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_data;
  logic          sdram_we, sdram_req, sdram_ack;
  logic          sdram_valid = 1'b0;
  logic [DW-1:0] sdram_q = '0;
  logic          err_orphan;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TAG_DEPTH  (TD)
  ) dut (
    .sys_clk     (clk),
    .rst         (rst),
    .p0_addr     (p0_addr),
    .p0_data     (p0_data),
    .p0_we       (p0_we),
    .p0_req      (p0_req),
    .p0_ack      (p0_ack),
    .p0_valid    (p0_valid),
    .p1_addr     (p1_addr),
    .p1_data     (p1_data),
    .p1_we       (p1_we),
    .p1_req      (p1_req),
    .p1_ack      (p1_ack),
    .p1_valid    (p1_valid),
    .rd_q        (rd_q),
    .sdram_addr  (sdram_addr),
    .sdram_data  (sdram_data),
    .sdram_we    (sdram_we),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .sdram_valid (sdram_valid),
    .sdram_q     (sdram_q),
    .err_orphan  (err_orphan)
  );

  // Controller stand-in: accepts a request in its second cycle when enabled.
  logic ack_en = 1'b1;
  int   req_age;
  always @(posedge clk or posedge rst) begin
    if (rst)                          req_age <= 0;
    else if (sdram_req && !sdram_ack) req_age <= req_age + 1;
    else                              req_age <= 0;
  end
  assign sdram_ack = ack_en && sdram_req && (req_age != 0);

  // Model: one granted transfer at a time, queue of read owners in issue order.
  bit            m_busy;
  int            m_owner;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_we;
  bit            m_orphan;
  int            m_last;
  int            m_q[$];
  int            glog[$];
  logic [DW-1:0] got0[$], got1[$];
  int            left0 = 0, left1 = 0;
  bit            ack_seen0 = 0, ack_seen1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_addr = '0; m_data = '0; m_we = 1'b0;
    m_orphan = 0; m_last = 1; m_q.delete();
    ack_seen0 = 0; ack_seen1 = 0;
  endtask

  // Called at the negedge: computes what holds after the coming posedge.
  task automatic model_advance();
    int  sz;
    bit  e0, e1;
    int  g;
    if (rst) begin
      model_reset();
      return;
    end
    sz = m_q.size();
    if (sdram_valid) begin
      if (sz > 0) void'(m_q.pop_front());
      else        m_orphan = 1;
    end
    if (m_busy) begin
      if (sdram_ack) begin
        if (!m_we) m_q.push_back(m_owner);
        m_busy = 0;
      end
    end else begin
      e0 = p0_req && (p0_we || sz < TD);
      e1 = p1_req && (p1_we || sz < TD);
      g = -1;
`ifdef SDRAM_ARB_RR_EN
      if (e0 && e1) g = (m_last == 0) ? 1 : 0;
      else if (e0)  g = 0;
      else if (e1)  g = 1;
`else
      if (e0)      g = 0;
      else if (e1) g = 1;
`endif
      if (g >= 0) begin
        m_busy = 1; m_owner = g; m_last = g;
        m_addr = (g == 0) ? p0_addr : p1_addr;
        m_data = (g == 0) ? p0_data : p1_data;
        m_we   = (g == 0) ? p0_we   : p1_we;
        glog.push_back(g);
      end
    end
  endtask

  task automatic compare_all();
    int hd;
    hd = (m_q.size() > 0) ? m_q[0] : -1;
    chk("sdram_req",  {63'd0, sdram_req}, {63'd0, m_busy});
    chk("sdram_addr", 64'(sdram_addr), 64'(m_addr));
    chk("sdram_data", 64'(sdram_data), 64'(m_data));
    chk("sdram_we",   {63'd0, sdram_we}, {63'd0, m_we});
    chk("p0_ack",   {63'd0, p0_ack},   {63'd0, m_busy && sdram_ack && m_owner == 0});
    chk("p1_ack",   {63'd0, p1_ack},   {63'd0, m_busy && sdram_ack && m_owner == 1});
    chk("p0_valid", {63'd0, p0_valid}, {63'd0, sdram_valid && hd == 0});
    chk("p1_valid", {63'd0, p1_valid}, {63'd0, sdram_valid && hd == 1});
    chk("rd_q",     64'(rd_q), 64'(sdram_q));
    chk("err_orphan", {63'd0, err_orphan}, {63'd0, m_orphan});
    if (p0_ack) ack_seen0 = 1;
    if (p1_ack) ack_seen1 = 1;
    if (p0_valid) got0.push_back(rd_q);
    if (p1_valid) got1.push_back(rd_q);
  endtask

  // One clock: compare and advance the model at the negedge, drive requesters at posedge+1.
  task automatic step();
    @(negedge clk);
    compare_all();
    model_advance();
    @(posedge clk);
    #1;
    sdram_valid = 1'b0;
    if (ack_seen0) begin
      ack_seen0 = 0;
      if (left0 > 1) begin left0--; p0_addr = p0_addr + 1'b1; p0_data = p0_data + 1'b1; end
      else begin left0 = 0; p0_req = 1'b0; end
    end
    if (ack_seen1) begin
      ack_seen1 = 0;
      if (left1 > 1) begin left1--; p1_addr = p1_addr + 1'b1; p1_data = p1_data + 1'b1; end
      else begin left1 = 0; p1_req = 1'b0; end
    end
  endtask

  task automatic issue(input int port, input logic [AW-1:0] a, input logic we,
                       input logic [DW-1:0] d, input int n);
    if (port == 0) begin p0_addr = a; p0_we = we; p0_data = d; p0_req = 1'b1; left0 = n; end
    else           begin p1_addr = a; p1_we = we; p1_data = d; p1_req = 1'b1; left1 = n; end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    step();
    while ((p0_req || p1_req || sdram_req) && n < LIM) begin step(); n++; end
    chk(tag, 64'(n < LIM), 64'd1);
  endtask

  task automatic pulse_valid(input logic [DW-1:0] q);
    sdram_valid = 1'b1;
    sdram_q     = q;
  endtask

  int exp_order[4];
  int n;

  initial begin
    model_reset();
`ifdef SDRAM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    // Reset
    repeat (3) step();
    chk("rst_sdram_req", {63'd0, sdram_req}, 64'd0);
    chk("rst_err_orphan", {63'd0, err_orphan}, 64'd0);
    chk("rst_p0_ack", {63'd0, p0_ack}, 64'd0);
    rst = 1'b0;
    step();

    // Contention: both ports request 4 writes each
    glog.delete();
    issue(0, 23'h100, 1'b1, 32'hA000, 4);
    issue(1, 23'h200, 1'b1, 32'hB000, 4);
    wait_idle("contention_idle");
    chk("grant_count", 64'(glog.size()), 64'd8);
    for (int i = 0; i < 4; i++) chk("grant_order", 64'(glog[i]), 64'(exp_order[i]));

    // Single read on port 0
    issue(0, 23'h55AA55, 1'b0, '0, 1);
    #1 chk("pre_grant_req", {63'd0, sdram_req}, 64'd0);
    step();
    chk("grant_req", {63'd0, sdram_req}, 64'd1);
    chk("grant_addr", 64'(sdram_addr), 64'h55AA55);
    wait_idle("single_idle");
    pulse_valid(32'h55AA55AA);
    #1;
    chk("single_p0_valid", {63'd0, p0_valid}, 64'd1);
    chk("single_rd_q", 64'(rd_q), 64'h55AA55AA);
    chk("single_p1_valid", {63'd0, p1_valid}, 64'd0);
    step();

    // Interleaved reads p1, p0, p1 with delayed valids
    got0.delete(); got1.delete();
    issue(1, 23'h10, 1'b0, '0, 1); wait_idle("il_a");
    issue(0, 23'h20, 1'b0, '0, 1); wait_idle("il_b");
    issue(1, 23'h30, 1'b0, '0, 1); wait_idle("il_c");
    pulse_valid(32'h1); step(); step();
    pulse_valid(32'h2); step(); step(); step();
    pulse_valid(32'h3); step();
    step();
    chk("il_p1_count", 64'(got1.size()), 64'd2);
    chk("il_p0_count", 64'(got0.size()), 64'd1);
    chk("il_p1_first", 64'(got1[0]), 64'h1);
    chk("il_p0_data", 64'(got0[0]), 64'h2);
    chk("il_p1_second", 64'(got1[1]), 64'h3);

    // Tag FIFO full: reads blocked, writes still granted
    issue(0, 23'h400, 1'b0, '0, TD);
    wait_idle("fill_idle");
    glog.delete();
    issue(0, 23'h77, 1'b0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_read_blocked", {63'd0, sdram_req}, 64'd0);
    end
    issue(1, 23'h300, 1'b1, 32'hDEAD, 1);
    step();
    chk("full_write_req", {63'd0, sdram_req}, 64'd1);
    chk("full_write_we", {63'd0, sdram_we}, 64'd1);
    chk("full_write_addr", 64'(sdram_addr), 64'h300);
    n = 0;
    while (p1_req && n < LIM) begin step(); n++; end
    chk("full_write_done", 64'(n < LIM), 64'd1);
    pulse_valid(32'hA0);
    step();
    n = 0;
    while ((p0_req || sdram_req) && n < LIM) begin step(); n++; end
    chk("full_read_done", 64'(n < LIM), 64'd1);
    chk("full_grant_count", 64'(glog.size()), 64'd2);
    chk("full_grant_first", 64'(glog[0]), 64'd1);
    chk("full_grant_second", 64'(glog[1]), 64'd0);
    for (int i = 0; i < int'(TD); i++) begin pulse_valid(32'hB0 + 32'(i)); step(); end
    step();

    // Orphan valid
    pulse_valid(32'hBAD);
    #1;
    chk("orphan_p0_valid", {63'd0, p0_valid}, 64'd0);
    chk("orphan_p1_valid", {63'd0, p1_valid}, 64'd0);
    step();
    chk("orphan_set", {63'd0, err_orphan}, 64'd1);
    repeat (3) step();
    chk("orphan_sticky", {63'd0, err_orphan}, 64'd1);

    // Reset while BUSY with two reads outstanding
    issue(0, 23'h500, 1'b0, '0, 2);
    wait_idle("pre_rst_idle");
    ack_en = 1'b0;
    issue(1, 23'h40, 1'b0, '0, 1);
    step(); step();
    chk("busy_before_rst", {63'd0, sdram_req}, 64'd1);
    rst = 1'b1;
    model_reset();
    p1_req = 1'b0; left1 = 0;
    #1;
    chk("rst_now_req", {63'd0, sdram_req}, 64'd0);
    chk("rst_now_addr", 64'(sdram_addr), 64'd0);
    chk("rst_now_we", {63'd0, sdram_we}, 64'd0);
    chk("rst_now_orphan", {63'd0, err_orphan}, 64'd0);
    ack_en = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    glog.delete();
    issue(1, 23'h99, 1'b0, '0, 1);
    wait_idle("post_rst_idle");
    chk("post_rst_grant", 64'(glog.size()), 64'd1);
    chk("post_rst_orphan", {63'd0, err_orphan}, 64'd0);
    pulse_valid(32'h5A);
    #1;
    chk("post_rst_p1_valid", {63'd0, p1_valid}, 64'd1);
    chk("post_rst_p0_valid", {63'd0, p0_valid}, 64'd0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
